// File: rtl/cluster_clock_gate_ctrl.sv
// rtl/cluster_clock_gate_ctrl.sv - cluster clock-enable controller with PMU req/ack handshake
// Optional idle auto-gating under CLUSTER_CLOCK_GATE_CTRL_AUTO_IDLE_EN.
module cluster_clock_gate_ctrl #(
    parameter int IdleCntWidth = 8,
    parameter int WakeCycles   = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    off_req_i,
    output logic                    off_ack_o,
    input  logic                    busy_i,
    input  logic                    wake_i,
    input  logic [IdleCntWidth-1:0] idle_thresh_i,
    output logic                    clk_en_o,
    output logic                    gated_o
);

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_OFF, ST_WAKE} state_t;

    localparam logic [3:0] WakeLoad = 4'(WakeCycles - 1);

    state_t     state_q, state_d;
    logic       by_req_q, by_req_d;
    logic [3:0] wake_cnt_q, wake_cnt_d;
    logic       clk_en_q, gated_q, off_ack_q;

`ifdef CLUSTER_CLOCK_GATE_CTRL_AUTO_IDLE_EN
    logic [IdleCntWidth-1:0] idle_cnt_q, idle_cnt_d;
    logic [IdleCntWidth:0]   idle_next;
    logic                    auto_off;

    assign idle_next = {1'b0, idle_cnt_q} + {{IdleCntWidth{1'b0}}, 1'b1};
    assign auto_off  = !busy_i && (idle_thresh_i != '0)
                       && (idle_next >= {1'b0, idle_thresh_i});

    // Counter is only alive in RUN; every other state and any busy sample clears it.
    always_comb begin
        idle_cnt_d = '0;
        if (state_q == ST_RUN && !off_req_i && !busy_i && !auto_off)
            idle_cnt_d = (&idle_cnt_q) ? idle_cnt_q : idle_next[IdleCntWidth-1:0];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) idle_cnt_q <= '0;
        else         idle_cnt_q <= idle_cnt_d;
    end
`else
    logic unused_auto_inputs;
    assign unused_auto_inputs = ^{idle_thresh_i, wake_i};
`endif

    always_comb begin
        state_d    = state_q;
        by_req_d   = by_req_q;
        wake_cnt_d = wake_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (off_req_i) begin
                    state_d = ST_DRAIN;
`ifdef CLUSTER_CLOCK_GATE_CTRL_AUTO_IDLE_EN
                end else if (auto_off) begin
                    state_d  = ST_OFF;
                    by_req_d = 1'b0;
`endif
                end
            end
            ST_DRAIN: begin
                if (!off_req_i) begin
                    state_d = ST_RUN;
                end else if (!busy_i) begin
                    state_d  = ST_OFF;
                    by_req_d = 1'b1;
                end
            end
            ST_OFF: begin
                if (by_req_q) begin
                    if (!off_req_i) begin
                        state_d    = ST_WAKE;
                        wake_cnt_d = WakeLoad;
                        by_req_d   = 1'b0;
                    end
                end else if (off_req_i) begin
                    // PMU adopts an auto-gated OFF; acknowledge without waking.
                    by_req_d = 1'b1;
`ifdef CLUSTER_CLOCK_GATE_CTRL_AUTO_IDLE_EN
                end else if (wake_i || busy_i) begin
`else
                end else if (busy_i) begin
`endif
                    state_d    = ST_WAKE;
                    wake_cnt_d = WakeLoad;
                    by_req_d   = 1'b0;
                end
            end
            ST_WAKE: begin
                if (wake_cnt_q == 4'd0) state_d = ST_RUN;
                else                    wake_cnt_d = wake_cnt_q - 4'd1;
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Outputs are registered from next-state so they change only at clock edges.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_RUN;
            by_req_q   <= 1'b0;
            wake_cnt_q <= 4'd0;
            clk_en_q   <= 1'b1;
            gated_q    <= 1'b0;
            off_ack_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            by_req_q   <= by_req_d;
            wake_cnt_q <= wake_cnt_d;
            clk_en_q   <= (state_d != ST_OFF);
            gated_q    <= (state_d == ST_OFF);
            off_ack_q  <= (state_d == ST_OFF) && by_req_d;
        end
    end

    assign clk_en_o  = clk_en_q;
    assign gated_o   = gated_q;
    assign off_ack_o = off_ack_q;

endmodule

// File: tb/tb_cluster_clock_gate_ctrl.sv
// tb/tb_cluster_clock_gate_ctrl.sv - directed + randomized check against a behavioural model
module tb_cluster_clock_gate_ctrl;

    localparam int W    = 8;
    localparam int WAKE = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         off_req = 1'b0;
    logic         busy = 1'b0;
    logic         wake = 1'b0;
    logic [W-1:0] thresh = '0;
    logic         off_ack, clk_en, gated;

    int checks = 0;
    int failures = 0;

    cluster_clock_gate_ctrl #(.IdleCntWidth(W), .WakeCycles(WAKE)) dut (
        .clk_i(clk), .rst_ni(rst_n), .off_req_i(off_req), .off_ack_o(off_ack),
        .busy_i(busy), .wake_i(wake), .idle_thresh_i(thresh),
        .clk_en_o(clk_en), .gated_o(gated)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Model: clock is "off" or not; when off, who owns it; how many wake cycles remain;
    // whether a request is waiting for drain; idle streak length.
    bit m_off, m_owned, m_drain;
    int m_wake_left, m_idle;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_off = 0; m_owned = 0; m_drain = 0; m_wake_left = 0; m_idle = 0;
        end else if (m_wake_left > 0) begin
            m_wake_left--;
            m_idle = 0;
        end else if (m_off) begin
            m_idle = 0;
            if (m_owned) begin
                if (!off_req) begin m_off = 0; m_owned = 0; m_wake_left = WAKE; end
            end else if (off_req) begin
                m_owned = 1;
            end else if (busy
`ifdef CLUSTER_CLOCK_GATE_CTRL_AUTO_IDLE_EN
                         || wake
`endif
                        ) begin
                m_off = 0; m_wake_left = WAKE;
            end
        end else if (m_drain) begin
            m_idle = 0;
            if (!off_req) m_drain = 0;
            else if (!busy) begin m_drain = 0; m_off = 1; m_owned = 1; end
        end else if (off_req) begin
            m_drain = 1;
            m_idle = 0;
        end else begin
`ifdef CLUSTER_CLOCK_GATE_CTRL_AUTO_IDLE_EN
            if (busy) m_idle = 0;
            else if (thresh != 0 && m_idle + 1 >= int'(thresh)) begin
                m_off = 1; m_owned = 0; m_idle = 0;
            end else m_idle = (m_idle + 1 > 255) ? 255 : m_idle + 1;
`endif
        end
    end

    always @(negedge clk) begin
        check("model_clk_en", clk_en, !m_off);
        check("model_gated", gated, m_off);
        check("model_off_ack", off_ack, m_off && m_owned);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        cyc(3);
        check("reset_clk_en", clk_en, 1'b1);
        check("reset_ack", off_ack, 1'b0);
        check("reset_gated", gated, 1'b0);
        rst_n = 1'b1;
        cyc(10);
        check("idle_clk_en", clk_en, 1'b1);
        check("idle_gated", gated, 1'b0);

        // Request path, busy low: ack two edges after request.
        off_req = 1'b1;
        cyc(1);
        check("req_drain_en", clk_en, 1'b1);
        check("req_drain_ack", off_ack, 1'b0);
        cyc(1);
        check("req_off_en", clk_en, 1'b0);
        check("req_off_ack", off_ack, 1'b1);
        check("req_off_gated", gated, 1'b1);
        cyc(3);
        off_req = 1'b0;
        cyc(1);
        check("rel_en", clk_en, 1'b1);
        check("rel_ack", off_ack, 1'b0);
        off_req = 1'b1;  // ignored in WAKE, taken on first RUN cycle
        cyc(1);
        check("wake_ign_en", clk_en, 1'b1);
        cyc(2);
        check("wake_req_en", clk_en, 1'b1);
        cyc(1);
        check("wake_req_off", clk_en, 1'b0);
        off_req = 1'b0;
        cyc(4);

        // Drain with busy high for five cycles.
        busy = 1'b1; off_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            check("drain_busy_en", clk_en, 1'b1);
        end
        busy = 1'b0;
        cyc(1);
        check("drain_done_ack", off_ack, 1'b1);
        off_req = 1'b0;
        cyc(4);

        // Abort from DRAIN.
        busy = 1'b1; off_req = 1'b1;
        cyc(2);
        off_req = 1'b0;
        cyc(3);
        check("abort_ack", off_ack, 1'b0);
        check("abort_en", clk_en, 1'b1);
        busy = 1'b0;

`ifdef CLUSTER_CLOCK_GATE_CTRL_AUTO_IDLE_EN
        thresh = 8'd4; busy = 1'b1;
        cyc(1);
        busy = 1'b0;
        cyc(3);
        check("auto_3rd_en", clk_en, 1'b1);
        cyc(1);
        check("auto_4th_en", clk_en, 1'b0);
        check("auto_ack", off_ack, 1'b0);
        wake = 1'b1;
        cyc(1);
        wake = 1'b0;
        check("auto_wake_en", clk_en, 1'b1);
        check("auto_wake_ack", off_ack, 1'b0);
        busy = 1'b1;
        cyc(3);
        busy = 1'b0;
        cyc(2);
        busy = 1'b1;  // pulse at third edge restarts the count
        cyc(1);
        busy = 1'b0;
        cyc(3);
        check("auto_restart_en", clk_en, 1'b1);
        cyc(1);
        check("auto_restart_off", clk_en, 1'b0);
        wake = 1'b1; off_req = 1'b1;
        cyc(1);
        wake = 1'b0;
        check("adopt_en", clk_en, 1'b0);
        check("adopt_ack", off_ack, 1'b1);
        off_req = 1'b0;
        thresh = '0;
        cyc(4);
`endif

        // Asynchronous reset while OFF.
        off_req = 1'b1;
        cyc(3);
        check("pre_rst_en", clk_en, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_en", clk_en, 1'b1);
        check("async_rst_ack", off_ack, 1'b0);
        check("async_rst_gated", gated, 1'b0);
        off_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1);
        off_req = 1'b1;
        cyc(2);
        check("post_rst_req_ack", off_ack, 1'b1);
        off_req = 1'b0;
        cyc(4);

        // Randomized phase: sticky levels so requests and idle streaks last.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 11) == 0) off_req = ~off_req;
            busy = ($urandom_range(0, 5) == 0);
            wake = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 199) == 0) thresh = W'($urandom_range(0, 8));
            cyc(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
